alu_operand_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_operand_sequencer_key_conditioner.sv | 71 +++++++
 rtl/alu_operand_sequencer.sv | 81 ++++++++
 tb/tb_alu_operand_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU operand sequencer.
package alu_seq_pkg;

  localparam int unsigned OPND_W = 3;
  localparam int unsigned RES_W  = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    CAPT   = 3'd4,
    SHOW   = 3'd5
  } seq_state_t;

  typedef enum logic [SEL_W-1:0] {
    FN_ADD = 2'b00,
    FN_SUB = 2'b01,
    FN_XOR = 2'b10,
    FN_SHL = 2'b11
  } alu_fn_t;

endpackage

// File: rtl/alu_operand_sequencer_key_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce
// (ALU_SEQ_DEBOUNCE_EN) and registered falling-edge press pulse.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  logic sync_q1;
  logic sync_q2;
  logic level;
  logic level_d;

  // Bring the asynchronous key into the clock domain (idle = released = 1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned CNT_W =
    ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] stable_cnt;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level      <= 1'b1;
      stable_cnt <= '0;
    end else if (sync_q2 == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
      level      <= sync_q2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end
`else
  // Accepted level tracks the synchronized key directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b1;
    end else begin
      level <= sync_q2;
    end
  end
`endif

  // Single-cycle registered pulse on each 1->0 transition of the accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Key-driven front end for the 3-bit ALU: collects A, B and the function
// code one key press at a time, then captures and holds the ALU result.
// Optional key debounce is enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPND_W-1:0] sw,
  input  logic              key_next,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_f,
  input  logic              alu_s,
  output logic [RES_W-1:0]  res_f,
  output logic              res_s,
  output logic              res_valid,
  output logic [2:0]        state_dbg,
  output logic [7:0]        op_count
);

  seq_state_t state;
  logic       press;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(key_next),
    .press  (press)
  );

  // Sequencer FSM with operand, capture and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= GET_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_f     <= '0;
      res_s     <= 1'b0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        GET_A: if (press) begin
          alu_a     <= sw;
          res_valid <= 1'b0;
          state     <= GET_B;
        end
        GET_B: if (press) begin
          alu_b <= sw;
          state <= GET_OP;
        end
        GET_OP: if (press) begin
          alu_sel <= sw[SEL_W-1:0];
          state   <= EXEC;
        end
        EXEC: state <= CAPT;
        CAPT: begin
          res_f     <= alu_f;
          res_s     <= alu_s;
          res_valid <= 1'b1;
          op_count  <= op_count + 8'd1;
          state     <= SHOW;
        end
        SHOW: if (press) begin
          state <= GET_A;
        end
        default: state <= GET_A;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with an ideal ALU model.
module tb_alu_operand_sequencer;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned LOW_N  = 20;
  localparam int unsigned HIGH_N = 20;
`else
  localparam int unsigned LOW_N  = 2;
  localparam int unsigned HIGH_N = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw;
  logic       key_next;
  logic [2:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [3:0] alu_f;
  logic       alu_s;
  logic [3:0] res_f;
  logic       res_s;
  logic       res_valid;
  logic [2:0] state_dbg;
  logic [7:0] op_count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] f;
    logic       s;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_count;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .key_next (key_next),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_f    (alu_f),
    .alu_s    (alu_s),
    .res_f    (res_f),
    .res_s    (res_s),
    .res_valid(res_valid),
    .state_dbg(state_dbg),
    .op_count (op_count)
  );

  // Ideal ALU seen by the DUT.
  always_comb begin
    alu_f = 4'd0;
    alu_s = 1'b1;
    case (alu_sel)
      2'b00: alu_f = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin alu_f = {1'b0, alu_a} - {1'b0, alu_b}; alu_s = 1'b0; end
      2'b10: alu_f = {1'b0, alu_a ^ alu_b};
      default: alu_f = {alu_a, 1'b0};
    endcase
  end

  function automatic logic [3:0] ref_f(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sel);
    case (sel)
      2'b00: return 4'(a) + 4'(b);
      2'b01: return 4'(a) - 4'(b);
      2'b10: return 4'(a ^ b);
      default: return {a, 1'b0};
    endcase
  endfunction

  task automatic press_key(input int unsigned low_cyc, input int unsigned high_cyc);
    key_next = 1'b0;
    repeat (low_cyc) begin @(posedge clk); #1; end
    key_next = 1'b1;
    repeat (high_cyc) begin @(posedge clk); #1; end
  endtask

  task automatic check_state(input string name, input logic [2:0] exp);
    compared++;
    if (state_dbg !== exp) begin
      mismatched++;
      $display("FAIL %s: state_dbg got %0d expected %0d", name, state_dbg, exp);
    end
  endtask

  // Waits for a capture and compares it against the oldest scoreboard entry.
  task automatic wait_result(input string name);
    int   n = 0;
    exp_t e;
    while (res_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    compared++;
    if (res_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_timeout: res_valid got %b expected 1", name, res_valid);
    end
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL %s_sb_empty: got 0 entries expected 1", name);
      return;
    end
    e = sb.pop_front();
    compared++;
    if (res_f !== e.f) begin
      mismatched++;
      $display("FAIL %s_res_f: got %b expected %b", name, res_f, e.f);
    end
    compared++;
    if (res_s !== e.s) begin
      mismatched++;
      $display("FAIL %s_res_s: got %b expected %b", name, res_s, e.s);
    end
    compared++;
    if (op_count !== e.cnt) begin
      mismatched++;
      $display("FAIL %s_op_count: got %0d expected %0d", name, op_count, e.cnt);
    end
    check_state({name, "_show"}, 3'd5);
  endtask

  task automatic enter_op(input string name, input logic [2:0] a, input logic [2:0] b,
                          input logic [1:0] sel, input logic [3:0] ef, input logic es,
                          input int unsigned a_low);
    if (state_dbg == 3'd5) begin
      press_key(LOW_N, HIGH_N);
      check_state({name, "_to_get_a"}, 3'd0);
    end
    sw = a;
    press_key(a_low, HIGH_N);
    check_state({name, "_to_get_b"}, 3'd1);
    compared++;
    if (alu_a !== a || res_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_alu_a: got a=%0d valid=%b expected a=%0d valid=0", name, alu_a, res_valid, a);
    end
    sw = b;
    press_key(LOW_N, HIGH_N);
    check_state({name, "_to_get_op"}, 3'd2);
    exp_count = exp_count + 8'd1;
    sb.push_back('{f: ef, s: es, cnt: exp_count});
    sw = {1'b0, sel};
    press_key(LOW_N, HIGH_N);
    compared++;
    if (alu_b !== b || alu_sel !== sel) begin
      mismatched++;
      $display("FAIL %s_alu_b_sel: got b=%0d sel=%0d expected b=%0d sel=%0d", name, alu_b, alu_sel, b, sel);
    end
    wait_result(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    exp_count = 8'd0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    check_state("reset_state", 3'd0);
    compared++;
    if (alu_a !== 3'd0 || alu_b !== 3'd0 || alu_sel !== 2'd0 || res_f !== 4'd0 ||
        res_s !== 1'b0 || res_valid !== 1'b0 || op_count !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got a=%0d b=%0d sel=%0d f=%0d s=%b v=%b cnt=%0d expected all 0",
               alu_a, alu_b, alu_sel, res_f, res_s, res_valid, op_count);
    end
  endtask

  task automatic test_ops();
    enter_op("add_3_2", 3'd3, 3'd2, 2'b00, 4'b0101, 1'b1, LOW_N);
    enter_op("sub_2_5", 3'd2, 3'd5, 2'b01, 4'b1101, 1'b0, LOW_N);
    enter_op("shl_7",   3'd7, 3'd0, 2'b11, 4'b1110, 1'b1, LOW_N);
    enter_op("xor_5_3", 3'd5, 3'd3, 2'b10, 4'b0110, 1'b1, LOW_N);
  endtask

  task automatic test_held_key();
    enter_op("held_key", 3'd4, 3'd1, 2'b00, 4'b0101, 1'b1, 100);
  endtask

`ifndef ALU_SEQ_DEBOUNCE_EN
  // Second press lands while the FSM is in CAPT and must be ignored.
  task automatic test_capt_discard();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    press_key(LOW_N, HIGH_N);
    check_state("discard_to_get_a", 3'd0);
    sw = 3'd6;
    press_key(LOW_N, HIGH_N);
    sw = 3'd1;
    press_key(LOW_N, HIGH_N);
    check_state("discard_to_get_op", 3'd2);
    exp_count = exp_count + 8'd1;
    sb.push_back('{f: 4'd7, s: 1'b1, cnt: exp_count});
    sw = 3'd0;
    key_next = 1'b0;
    @(posedge clk); #1; key_next = 1'b1;
    @(posedge clk); #1; key_next = 1'b0;
    @(posedge clk); #1; key_next = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_state($sformatf("discard_seq%0d", i), exp_seq[i]);
    end
    repeat (4) @(negedge clk);
    wait_result("discard");
  endtask
`endif

  task automatic test_reset_mid();
    press_key(LOW_N, HIGH_N);
    sw = 3'd6;
    press_key(LOW_N, HIGH_N);
    sw = 3'd2;
    press_key(LOW_N, HIGH_N);
    check_state("rstmid_get_op", 3'd2);
    compared++;
    if (alu_a !== 3'd6) begin
      mismatched++;
      $display("FAIL rstmid_alu_a_pre: got %0d expected 6", alu_a);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count = 8'd0;
    check_state("rstmid_state", 3'd0);
    compared++;
    if (alu_a !== 3'd0 || res_valid !== 1'b0 || op_count !== 8'd0 || res_f !== 4'd0) begin
      mismatched++;
      $display("FAIL rstmid_outputs: got a=%0d v=%b cnt=%0d f=%0d expected 0 0 0 0",
               alu_a, res_valid, op_count, res_f);
    end
  endtask

`ifdef ALU_SEQ_DEBOUNCE_EN
  task automatic test_debounce();
    enter_op("db_op", 3'd1, 3'd1, 2'b00, 4'b0010, 1'b1, LOW_N);
    press_key(5, 20);
    check_state("db_glitch", 3'd5);
    press_key(20, 20);
    check_state("db_press", 3'd0);
  endtask
`endif

  task automatic test_wrap();
    logic [2:0] a, b;
    logic [1:0] sel;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a   = 3'($urandom_range(0, 7));
      b   = 3'($urandom_range(0, 7));
      sel = 2'($urandom_range(0, 3));
      enter_op($sformatf("wrap%0d", i), a, b, sel, ref_f(a, b, sel), (sel != 2'b01), LOW_N);
    end
    compared++;
    if (op_count !== 8'd0) begin
      mismatched++;
      $display("FAIL wrap_final: op_count got %0d expected 0", op_count);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    sw       = 3'd0;
    key_next = 1'b1;
    exp_count = 8'd0;
    @(posedge clk); #1;
    test_reset();
    test_ops();
    test_held_key();
`ifndef ALU_SEQ_DEBOUNCE_EN
    test_capt_discard();
`endif
    test_reset_mid();
`ifdef ALU_SEQ_DEBOUNCE_EN
    test_debounce();
`endif
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
